gascon_inverse_round: RTL
=========================

# gascon_inverse_round

Iterative inverse of one Gascon permutation round on the 320-bit state. It undoes the forward round: first the inverse linear layer, then the inverse S-box, then removal of the round constant. It sits beside the forward round datapath and serves decryption and verification paths that must walk the permutation backwards. It also gives the verification bench an exact round-trip check.

## Interface
- CWIDTH, 320, state width; only 320 is supported (5 words of 64 bits).
- RW, 4, width of the round index.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- start  in  1  request strobe; sampled only in IDLE.
- round  in  RW  round index of the forward round being inverted; captured with start.
- c  in  CWIDTH  forward-round output state; captured with start.
- cout  out  CWIDTH  registered inverted state; reset value 0; held until the next completion.
- busy  out  1  high from the acceptance edge through the DONE cycle; reset value 0.
- done  out  1  one-cycle pulse, cout valid; reset value 0.

## Operation
- Word i is c[i*64 +: 64]; MID = 2. S-box column j is {w0[j],w1[j],w2[j],w3[j],w4[j]}, with w0 as MSB.
- Forward linear map per word: L(x) = x ^ rotr(x,a) ^ rotr(x,b).
  - (a,b) per word: w0 (19,28), w1 (61,39), w2 (1,6), w3 (10,17), w4 (7,41).
  - These amounts are identical to linlayer.
- Inverse linear map: L^-1 = L^63, applied as six sequential steps k = 0..5.
  - Step k: x ^ rotr(x, a·2^k mod 64) ^ rotr(x, b·2^k mod 64), on all 5 words in parallel.
  - One step per cycle. Only one shared step datapath, selected by a 3-bit step counter.
- Inverse S-box, applied to all 64 columns in one cycle. Input 0..31 maps to: 14 1A 07 0D 00 09 0E 12 0A 06 1D 01 19 15 13 1E 18 16 0B 11 03 05 1C 1F 17 1B 04 08 0F 0C 10 02 (hex).
- Constant removal happens in the same cycle as the S-box: w2 ^= {56'b0, (4'hF - round[3:0]), round[3:0]}.
  - Subtraction is 4-bit and wraps.
  - Only the low RW bits of round are used; for RW > 4, only round[3:0] enter the constant.
- FSM states: IDLE, LINV, SINV, DONE.
  - IDLE: on start=1, load state ← c, rnd ← round, k ← 0, go to LINV.
  - LINV: apply step k; k ← k+1. Go to SINV after k = 5.
  - SINV: apply inverse S-box and constant removal; load cout; go to DONE.
  - DONE: done = 1; return to IDLE unconditionally.
- Ignored inputs:
  - start in LINV, SINV or DONE is ignored and is not queued.
  - c and round are ignored except at the acceptance edge.
- Reset asserted at any time:
  - state goes to IDLE; k, rnd, internal state and cout clear to 0.
  - busy = done = 0 immediately; any in-flight operation is discarded.
  - Deassertion takes effect at the next rising edge.

## Timing
- E0 is the edge that samples start = 1 in IDLE. Then:
  - E1..E6 perform linear steps k = 0..5.
  - E7 performs the S-box and constant step and updates cout.
  - done is high for the cycle between E7 and E8.
  - E8 returns the FSM to IDLE.
- Latency from acceptance to done is 7 cycles. Fastest throughput is one operation per 9 cycles, since a new start is accepted at E9 at the earliest.
- busy rises after E0 and falls after E8. start held high continuously therefore restarts on every IDLE cycle.
- cout changes only at E7 or on reset.

## Test plan
- c = 0, round = 0, with reset released → done at E7; cout words w0..w4 = FFFFFFFFFFFFFFFF, 0, FFFFFFFFFFFFFF0F, 0, 0.
- c = all ones, round = 3 → cout = w3 FFFFFFFFFFFFFFFF, w2 00000000000000C3, w0 = w1 = w4 = 0.
- Round-trip: 1000 random states and rounds 0..15 through the team's forward Gascon round, then this block → cout equals the original state bit-exactly.
- Pulse start every cycle during LINV and SINV → exactly one done per accepted start; cout changes only at E7; busy stays high throughout.
- Assert reset at E4 of an operation → busy, done and cout read 0 before the next edge. After release, a new start completes normally in 7 cycles.
- Back-to-back: start held high for 30 cycles → done pulses spaced exactly 9 cycles apart, each cout correct for the c present at its acceptance edge.

Source files
------------

// File: rtl/gascon_inverse_round.sv
// Iterative inverse of one Gascon round on a 320-bit state:
// six L^(2^k) linear steps, then inverse S-box with round-constant removal.
module gascon_inverse_round #(
    parameter int unsigned CWIDTH = 320,
    parameter int unsigned RW     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [RW-1:0]     round,
    input  logic [CWIDTH-1:0] c,
    output logic [CWIDTH-1:0] cout,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LINV,
        ST_SINV,
        ST_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        step_q, step_d;
    logic [3:0]        rnd_q, rnd_d;
    logic [CWIDTH-1:0] st_q, st_d;
    logic [CWIDTH-1:0] cout_q, cout_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [3:0]        rnd_in;
    logic [CWIDTH-1:0] lin_out;
    logic [CWIDTH-1:0] sbox_out;

    // Only the low four round bits ever reach the constant.
    if (RW >= 4) begin : g_rnd_wide
        assign rnd_in = round[3:0];
    end else begin : g_rnd_narrow
        assign rnd_in = {{(4 - RW){1'b0}}, round};
    end

    function automatic logic [5:0] rot_a(input int unsigned idx);
        case (idx)
            0:       rot_a = 6'd19;
            1:       rot_a = 6'd61;
            2:       rot_a = 6'd1;
            3:       rot_a = 6'd10;
            default: rot_a = 6'd7;
        endcase
    endfunction

    function automatic logic [5:0] rot_b(input int unsigned idx);
        case (idx)
            0:       rot_b = 6'd28;
            1:       rot_b = 6'd39;
            2:       rot_b = 6'd6;
            3:       rot_b = 6'd17;
            default: rot_b = 6'd41;
        endcase
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input logic [5:0] n);
        logic [127:0] t;
        t = {x, x} >> n;
        return t[63:0];
    endfunction

    // L^(2^k) = x ^ rotr(x, a*2^k) ^ rotr(x, b*2^k); the 6-bit shift wraps mod 64.
    function automatic logic [CWIDTH-1:0] lin_step(input logic [CWIDTH-1:0] s,
                                                   input logic [2:0] k);
        logic [CWIDTH-1:0] r;
        logic [63:0]       x;
        logic [5:0]        sa;
        logic [5:0]        sb;
        r = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            x  = s[i*64 +: 64];
            sa = rot_a(i) << k;
            sb = rot_b(i) << k;
            r[i*64 +: 64] = x ^ rotr64(x, sa) ^ rotr64(x, sb);
        end
        return r;
    endfunction

    function automatic logic [4:0] sbox_inv(input logic [4:0] v);
        case (v)
            5'h00: sbox_inv = 5'h14;
            5'h01: sbox_inv = 5'h1A;
            5'h02: sbox_inv = 5'h07;
            5'h03: sbox_inv = 5'h0D;
            5'h04: sbox_inv = 5'h00;
            5'h05: sbox_inv = 5'h09;
            5'h06: sbox_inv = 5'h0E;
            5'h07: sbox_inv = 5'h12;
            5'h08: sbox_inv = 5'h0A;
            5'h09: sbox_inv = 5'h06;
            5'h0A: sbox_inv = 5'h1D;
            5'h0B: sbox_inv = 5'h01;
            5'h0C: sbox_inv = 5'h19;
            5'h0D: sbox_inv = 5'h15;
            5'h0E: sbox_inv = 5'h13;
            5'h0F: sbox_inv = 5'h1E;
            5'h10: sbox_inv = 5'h18;
            5'h11: sbox_inv = 5'h16;
            5'h12: sbox_inv = 5'h0B;
            5'h13: sbox_inv = 5'h11;
            5'h14: sbox_inv = 5'h03;
            5'h15: sbox_inv = 5'h05;
            5'h16: sbox_inv = 5'h1C;
            5'h17: sbox_inv = 5'h1F;
            5'h18: sbox_inv = 5'h17;
            5'h19: sbox_inv = 5'h1B;
            5'h1A: sbox_inv = 5'h04;
            5'h1B: sbox_inv = 5'h08;
            5'h1C: sbox_inv = 5'h0F;
            5'h1D: sbox_inv = 5'h0C;
            5'h1E: sbox_inv = 5'h10;
            default: sbox_inv = 5'h02;
        endcase
    endfunction

    // Column j is {w0[j],w1[j],w2[j],w3[j],w4[j]} with w0 as the MSB.
    function automatic logic [CWIDTH-1:0] sbox_layer(input logic [CWIDTH-1:0] s,
                                                     input logic [3:0] rnd);
        logic [CWIDTH-1:0] r;
        logic [4:0]        v;
        logic [4:0]        o;
        r = '0;
        for (int unsigned j = 0; j < 64; j++) begin
            v = {s[j], s[64+j], s[128+j], s[192+j], s[256+j]};
            o = sbox_inv(v);
            r[j]     = o[4];
            r[64+j]  = o[3];
            r[128+j] = o[2];
            r[192+j] = o[1];
            r[256+j] = o[0];
        end
        r[128 +: 64] = r[128 +: 64] ^ {56'b0, 4'hF - rnd, rnd};
        return r;
    endfunction

    always_comb begin
        lin_out  = lin_step(st_q, step_q);
        sbox_out = sbox_layer(st_q, rnd_q);

        state_d = state_q;
        step_d  = step_q;
        rnd_d   = rnd_q;
        st_d    = st_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LINV;
                    st_d    = c;
                    rnd_d   = rnd_in;
                    step_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_LINV: begin
                st_d   = lin_out;
                step_d = step_q + 3'd1;
                if (step_q == 3'd5) begin
                    state_d = ST_SINV;
                end
            end
            ST_SINV: begin
                cout_d  = sbox_out;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            rnd_q   <= '0;
            st_q    <= '0;
            cout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            rnd_q   <= rnd_d;
            st_q    <= st_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign cout = cout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
